// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/compare/branch ops plus an iterative
// shift-add multiplier, valid/ready handshake on both sides, registered outputs.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken
);

  localparam int unsigned ShW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, ma_q, ma_d, mb_q, mb_d;
  logic [ShW-1:0]   cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             branch_q, branch_d;

  logic [1:0]       alu_op;
  logic [3:0]       func;
  logic [ShW-1:0]   shamt;
  logic             flag;
  logic [WIDTH-1:0] arith;
  logic [WIDTH-1:0] sc_result;
  logic             sc_branch;
  logic             is_mul;
  logic             accept;
  logic [WIDTH-1:0] acc_next;

  assign alu_op   = alu_ctrl[5:4];
  assign func     = alu_ctrl[3:0];
  assign shamt    = op_b[ShW-1:0];
  assign is_mul   = (alu_op == 2'b01) && (func == 4'b1000);
  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  always_comb begin
    flag = 1'b0;
    unique case (func)
      4'b0000: flag = (op_a == op_b);
      4'b0001: flag = (op_a != op_b);
      4'b0010: flag = ($signed(op_a) < $signed(op_b));
      4'b0011: flag = (op_a < op_b);
      4'b0100: flag = ($signed(op_a) >= $signed(op_b));
      4'b0101: flag = (op_a >= op_b);
      default: flag = 1'b0;
    endcase

    arith = '0;
    unique case (func)
      4'b0000: arith = op_a + op_b;
      4'b0001: arith = op_a - op_b;
      4'b0010: arith = op_a & op_b;
      4'b0011: arith = op_a | op_b;
      4'b0100: arith = op_a ^ op_b;
      4'b0101: arith = op_a << shamt;
      4'b0110: arith = op_a >> shamt;
      4'b0111: arith = $signed(op_a) >>> shamt;
      default: arith = '0;
    endcase

    sc_result = '0;
    sc_branch = 1'b0;
    unique case (alu_op)
      2'b01:   sc_result = arith;
      2'b00:   sc_result = {{(WIDTH-1){1'b0}}, flag};
      2'b11:   sc_branch = flag;
      default: sc_result = '0;
    endcase
  end

  assign acc_next = acc_q + (mb_q[0] ? ma_q : '0);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    branch_d    = branch_q;
    out_valid_d = out_valid_q && !out_ready;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            state_d = StMul;
            acc_d   = '0;
            cnt_d   = '0;
            ma_d    = op_a;
            mb_d    = op_b;
          end else begin
            result_d    = sc_result;
            zero_d      = (sc_result == '0);
            branch_d    = sc_branch;
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d = acc_next;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + ShW'(1);
        if (cnt_q == ShW'(WIDTH - 1)) begin
          result_d    = acc_next;
          zero_d      = (acc_next == '0);
          branch_d    = 1'b0;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      branch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      branch_q    <= branch_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign branch_taken = branch_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes model results on accept,
// a negedge monitor pops and compares on each output handshake.
module tb_alu_exec_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [5:0]   alu_ctrl;
  logic [W-1:0] op_a, op_b, result;
  logic         zero, branch_taken;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [W+1:0] exp_q[$];
  bit rand_ready = 0;
  bit holding = 0;
  logic [W+1:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: {branch_taken, zero, result}
  function automatic logic [W+1:0] model(input logic [5:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic         flag;
    logic         br;
    logic [W-1:0] r;
    int           sh;
    sh = int'(b[3:0]);
    case (c[3:0])
      4'd0:    flag = (a == b);
      4'd1:    flag = (a != b);
      4'd2:    flag = ($signed(a) < $signed(b));
      4'd3:    flag = (a < b);
      4'd4:    flag = ($signed(a) >= $signed(b));
      4'd5:    flag = (a >= b);
      default: flag = 1'b0;
    endcase
    r  = '0;
    br = 1'b0;
    if (c[5:4] == 2'b01) begin
      case (c[3:0])
        4'd0:    r = a + b;
        4'd1:    r = a - b;
        4'd2:    r = a & b;
        4'd3:    r = a | b;
        4'd4:    r = a ^ b;
        4'd5:    r = a << sh;
        4'd6:    r = a >> sh;
        4'd7:    r = $signed(a) >>> sh;
        4'd8:    r = a * b;
        default: r = '0;
      endcase
    end else if (c[5:4] == 2'b00) begin
      r = W'(flag);
    end else if (c[5:4] == 2'b11) begin
      br = flag;
    end
    return {br, (r == '0), r};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int acc_edge);
    bit ok = 0;
    int n = 0;
    acc_edge = -1;
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        exp_q.push_back(model(c, a, b));
        acc_edge = cyc + 1;
      end
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    alu_ctrl = 6'($urandom);
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 500);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = (($urandom % 4) != 0);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 0;
    end else begin
      if (holding) check("hold_stable", 32'({branch_taken, zero, result}), 32'(held));
      holding = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 32'(out_valid), 32'd0);
        else check("scoreboard", 32'({branch_taken, zero, result}), 32'(exp_q.pop_front()));
      end else if (out_valid) begin
        held    = {branch_taken, zero, result};
        holding = 1;
      end
    end
  end

  initial begin
    int e1, e2, em, e2nd, ex, ey, raise_edge, dummy;
    bit seen;
    logic [5:0] c;
    logic [W-1:0] a, b;

    in_valid = 0; alu_ctrl = '0; op_a = '0; op_b = '0; out_ready = 1'b1;

    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_outputs", 32'({branch_taken, zero, result}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Wrapping ADD then SUB, back to back
    issue(6'b01_0000, 16'hFFFF, 16'h0001, e1);
    check("add_wrap_result", 32'({zero, result}), 32'h1_0000);
    issue(6'b01_0001, 16'h0005, 16'h0005, e2);
    check("sub_zero_result", 32'({zero, result}), 32'h1_0000);
    check("add_sub_throughput", e2 - e1, 1);

    issue(6'b01_0111, 16'h8000, 16'h0004, dummy);
    check("sra_result", 32'(result), 32'hF800);
    issue(6'b01_0101, 16'h0001, 16'h0013, dummy);
    check("sll_result", 32'(result), 32'h0008);

    issue(6'b11_0010, 16'hFFFE, 16'h0001, dummy);
    check("blt_taken", 32'({branch_taken, result}), 32'h1_0000);
    issue(6'b11_0011, 16'hFFFE, 16'h0001, dummy);
    check("bltu_not_taken", 32'({branch_taken, result}), 32'h0_0000);

    // MUL latency with a second request held behind it
    drain();
    issue(6'b01_1000, 16'h0012, 16'h0034, em);
    fork
      issue(6'b01_0000, 16'h1111, 16'h2222, e2nd);
      begin
        for (int k = 1; k <= W; k++) begin
          @(negedge clk);
          check("mul_busy_in_ready", 32'(in_ready), 0);
          check("mul_busy_out_valid", 32'(out_valid), 0);
        end
        @(negedge clk);
        check("mul_done_valid", 32'(out_valid), 1);
        check("mul_result", 32'(result), 32'h03A8);
      end
    join
    check("held_req_accept_edge", e2nd, em + W + 1);

    // Back-pressure
    drain();
    out_ready = 1'b0;
    issue(6'b01_0000, 16'h0003, 16'h0004, ex);
    fork
      issue(6'b01_0100, 16'h00F0, 16'h0F0F, ey);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 0);
          check("bp_out_valid", 32'(out_valid), 1);
          check("bp_result", 32'(result), 32'h0007);
        end
        @(posedge clk);
        #1;
        out_ready  = 1'b1;
        raise_edge = cyc;
      end
    join
    check("bp_release_accept", ey, raise_edge + 1);

    // Reset in the middle of a MUL
    drain();
    issue(6'b01_1000, 16'h0123, 16'h0045, dummy);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midmul_rst_outputs", 32'({out_valid, branch_taken, zero, result}), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midmul_in_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("aborted_mul_no_output", 32'(seen), 0);

    // Randomized traffic with random back-pressure
    @(posedge clk);
    #1;
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
      c[5:4] = 2'($urandom);
      c[3:0] = (($urandom % 8) == 0) ? 4'b1000 : 4'($urandom);
      a = W'($urandom);
      b = (($urandom % 4) == 0) ? a : W'($urandom);
      issue(c, a, b, dummy);
    end
    @(negedge clk);
    rand_ready = 0;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
